// File: rtl/pe_row_conv.sv
// Row-stationary convolution PE: caches all filter rows and one ifmap row, then streams out
// ipsum + 1-D dot products in (ifmap, filter, output column) order over enable/ready NoC ports.
module pe_row_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ifmap_noc,
  input  logic        ifmap_enable,
  input  logic [7:0]  weight_noc,
  input  logic        weight_enable,
  input  logic [23:0] ipsum_noc,
  input  logic        ipsum_enable,
  input  logic [3:0]  iw_size,
  input  logic [3:0]  c,
  input  logic [3:0]  f,
  input  logic [3:0]  n,
  input  logic [3:0]  o,
  input  logic        opsum_ready,
  output logic        ifmap_ready,
  output logic        weight_ready,
  output logic        ipsum_ready,
  output logic        opsum_enable,
  output logic [23:0] opsum_noc,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a word moves on the rising edge where enable && ready are both high. Input readies
  // drop for one cycle after every transfer; opsum_noc is held while opsum_enable is high.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_I = 3'd2,
    S_MAC    = 3'd3,
    S_PSUM   = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  w_cnt_q, w_cnt_d;
  logic [5:0]  i_cnt_q, i_cnt_d;
  logic        w_gap_q, w_gap_d;
  logic        i_gap_q, i_gap_d;
  logic [1:0]  s_q, s_d;
  logic [3:0]  ch_q, ch_d;
  logic [3:0]  p_q, p_d;
  logic [3:0]  fi_q, fi_d;
  logic [3:0]  ni_q, ni_d;
  logic [23:0] acc_q, acc_d;
  logic [23:0] psum_q, psum_d;
  logic        have_psum_q, have_psum_d;
  logic [23:0] opsum_q, opsum_d;

  logic signed [7:0] wspad [0:47];
  logic signed [7:0] ispad [0:39];

  logic [5:0] c_num, f_num, c3, cf, w_last, i_last;
  logic [5:0] w_rd_addr, i_rd_addr;
  logic signed [7:0]  w_rd, i_rd;
  logic signed [15:0] prod;
  logic [23:0] prod_ext;
  logic w_xfer, i_xfer, p_xfer;
  logic mac_first, mac_last;
  logic unused_cfg;

  assign unused_cfg = ^o;

  assign c_num  = 6'(c) + 6'd1;
  assign f_num  = 6'(f) + 6'd1;
  assign c3     = c_num + c_num + c_num;
  assign cf     = c_num * f_num;
  assign w_last = cf + cf + cf - 6'd1;
  assign i_last = (6'(iw_size) + 6'd2) * c_num - 6'd1;

  assign weight_ready = (state_q == S_LOAD_W) && !w_gap_q;
  assign ifmap_ready  = (state_q == S_LOAD_I) && !i_gap_q;
  assign ipsum_ready  = ((state_q == S_MAC) || (state_q == S_PSUM)) && !have_psum_q;
  // The MAC phase after each opsum is at least three cycles, which guarantees the enable gap.
  assign opsum_enable = (state_q == S_OUT);
  assign opsum_noc    = opsum_q;
  assign dbg_state_o  = state_q;

  assign w_xfer = weight_enable && weight_ready;
  assign i_xfer = ifmap_enable && ifmap_ready;
  assign p_xfer = ipsum_enable && ipsum_ready;

  assign w_rd_addr = 6'(fi_q) * c3 + 6'(s_q) * c_num + 6'(ch_q);
  assign i_rd_addr = (6'(p_q) + 6'(s_q)) * c_num + 6'(ch_q);
  assign w_rd      = wspad[w_rd_addr];
  assign i_rd      = ispad[i_rd_addr];
  assign prod      = w_rd * i_rd;
  assign prod_ext  = {{8{prod[15]}}, prod};
  assign mac_first = (s_q == 2'd0) && (ch_q == 4'd0);
  assign mac_last  = (s_q == 2'd2) && (ch_q == c);

  always_ff @(posedge clk) begin
    if (w_xfer) wspad[w_cnt_q] <= weight_noc;
    if (i_xfer) ispad[i_cnt_q] <= ifmap_noc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      w_cnt_q     <= '0;
      i_cnt_q     <= '0;
      w_gap_q     <= 1'b0;
      i_gap_q     <= 1'b0;
      s_q         <= '0;
      ch_q        <= '0;
      p_q         <= '0;
      fi_q        <= '0;
      ni_q        <= '0;
      acc_q       <= '0;
      psum_q      <= '0;
      have_psum_q <= 1'b0;
      opsum_q     <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      i_cnt_q     <= i_cnt_d;
      w_gap_q     <= w_gap_d;
      i_gap_q     <= i_gap_d;
      s_q         <= s_d;
      ch_q        <= ch_d;
      p_q         <= p_d;
      fi_q        <= fi_d;
      ni_q        <= ni_d;
      acc_q       <= acc_d;
      psum_q      <= psum_d;
      have_psum_q <= have_psum_d;
      opsum_q     <= opsum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    i_cnt_d     = i_cnt_q;
    w_gap_d     = w_xfer;
    i_gap_d     = i_xfer;
    s_d         = s_q;
    ch_d        = ch_q;
    p_d         = p_q;
    fi_d        = fi_q;
    ni_d        = ni_q;
    acc_d       = acc_q;
    psum_d      = psum_q;
    have_psum_d = have_psum_q;
    opsum_d     = opsum_q;

    // The ipsum for the current output point may arrive any time during MAC or PSUM.
    if (p_xfer) begin
      psum_d      = ipsum_noc;
      have_psum_d = 1'b1;
    end

    case (state_q)
      S_IDLE: state_d = S_LOAD_W;

      S_LOAD_W: begin
        if (w_xfer) begin
          if (w_cnt_q == w_last) begin
            w_cnt_d = '0;
            state_d = S_LOAD_I;
          end else begin
            w_cnt_d = w_cnt_q + 6'd1;
          end
        end
      end

      S_LOAD_I: begin
        if (i_xfer) begin
          if (i_cnt_q == i_last) begin
            i_cnt_d = '0;
            state_d = S_MAC;
          end else begin
            i_cnt_d = i_cnt_q + 6'd1;
          end
        end
      end

      S_MAC: begin
        acc_d = mac_first ? prod_ext : acc_q + prod_ext;
        if (mac_last) begin
          s_d     = '0;
          ch_d    = '0;
          state_d = S_PSUM;
        end else if (ch_q == c) begin
          ch_d = '0;
          s_d  = s_q + 2'd1;
        end else begin
          ch_d = ch_q + 4'd1;
        end
      end

      S_PSUM: begin
        if (have_psum_q) begin
          opsum_d = acc_q + psum_q;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (opsum_ready) begin
          have_psum_d = 1'b0;
          state_d     = S_MAC;
          if (p_q == iw_size - 4'd1) begin
            p_d = '0;
            if (fi_q == f) begin
              fi_d = '0;
              if (ni_q == n) begin
                state_d = S_DONE;
              end else begin
                ni_d    = ni_q + 4'd1;
                state_d = S_LOAD_I;
              end
            end else begin
              fi_d = fi_q + 4'd1;
            end
          end else begin
            p_d = p_q + 4'd1;
          end
        end
      end

      S_DONE: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_row_conv.sv
// Bench for pe_row_conv: stream drivers on the three input ports, an opsum monitor popping an
// expected queue, and scenarios for the main/minimal/wrap vectors, backpressure, gaps and abort.
module tb_pe_row_conv;

  localparam int TMO  = 4000;
  localparam int TMO2 = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ifmap_noc, weight_noc;
  logic        ifmap_enable, weight_enable, ipsum_enable;
  logic [23:0] ipsum_noc;
  logic [3:0]  iw_size, c, f, n, o;
  logic        opsum_ready;
  logic        ifmap_ready, weight_ready, ipsum_ready, opsum_enable;
  logic [23:0] opsum_noc;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  pe_row_conv dut (
    .clk(clk), .rst(rst),
    .ifmap_noc(ifmap_noc), .ifmap_enable(ifmap_enable),
    .weight_noc(weight_noc), .weight_enable(weight_enable),
    .ipsum_noc(ipsum_noc), .ipsum_enable(ipsum_enable),
    .iw_size(iw_size), .c(c), .f(f), .n(n), .o(o),
    .opsum_ready(opsum_ready),
    .ifmap_ready(ifmap_ready), .weight_ready(weight_ready),
    .ipsum_ready(ipsum_ready), .opsum_enable(opsum_enable),
    .opsum_noc(opsum_noc), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wv[$], iv[$], pv[$], ev[$];
  logic [23:0] exp_q[$];
  int ready_mode = 0;
  int n_out = 0;
  int since_xfer = 100;
  bit abort = 1'b0;
  bit gaps_en = 1'b0;
  logic hold_v = 1'b0;
  logic [23:0] hold_d;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Opsum monitor: decides opsum_ready for the coming edge and scores any transfer on it.
  always @(negedge clk) begin
    opsum_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (since_xfer < 100) since_xfer++;
    if (opsum_enable) begin
      check("opsum_gap", int'(since_xfer >= 3), 1);
      if (hold_v) check("opsum_hold", int'($signed(opsum_noc)), int'($signed(hold_d)));
      if (opsum_ready) begin
        if (exp_q.size() == 0) check("opsum_extra", 1, 0);
        else check("opsum", int'($signed(opsum_noc)), int'($signed(exp_q.pop_front())));
        n_out++;
        since_xfer = 0;
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = opsum_noc;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic logic port_ready(input int sel);
    case (sel)
      0: return weight_ready;
      1: return ifmap_ready;
      default: return ipsum_ready;
    endcase
  endfunction

  task automatic set_port(input int sel, input logic en, input int d);
    case (sel)
      0: begin weight_enable = en; weight_noc = 8'(d); end
      1: begin ifmap_enable = en; ifmap_noc = 8'(d); end
      default: begin ipsum_enable = en; ipsum_noc = 24'(d); end
    endcase
  endtask

  // Entered and left on a negedge; the word moves on the posedge between the last two negedges.
  task automatic drv(input int sel, input int d);
    int t;
    t = 0;
    if (gaps_en) begin
      set_port(sel, 1'b0, d);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    set_port(sel, 1'b1, d);
    while (!port_ready(sel) && !abort && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check("ready_timeout", t, 0);
    if (!abort) @(negedge clk);
  endtask

  task automatic stream_w();
    foreach (wv[k]) if (!abort) drv(0, wv[k]);
    weight_enable = 1'b0;
  endtask

  task automatic stream_i();
    foreach (iv[k]) if (!abort) drv(1, iv[k]);
    ifmap_enable = 1'b0;
  endtask

  task automatic stream_p();
    foreach (pv[k]) begin
      if (!abort) begin
        drv(2, pv[k]);
        if (!abort) exp_q.push_back(24'(ev[k]));
      end
    end
    ipsum_enable = 1'b0;
  endtask

  task automatic watch_abort(input int after);
    int t;
    t = 0;
    if (after > 0) begin
      while (n_out < after && t < TMO2) begin
        @(negedge clk);
        t++;
      end
      check("abort_reach", int'(n_out >= after), 1);
      @(negedge clk);
      rst = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      check("abort_opsum_en", int'(opsum_enable), 0);
      check("abort_opsum", int'(opsum_noc), 0);
      check("abort_readies", int'({weight_ready, ifmap_ready, ipsum_ready}), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    weight_enable = 1'b0; ifmap_enable = 1'b0; ipsum_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_readies", int'({weight_ready, ifmap_ready, ipsum_ready}), 0);
    check("rst_opsum_en", int'(opsum_enable), 0);
    check("rst_opsum", int'(opsum_noc), 0);
    rst = 1'b0;
  endtask

  task automatic run_case(input string name, input int mode, input bit gaps, input bit bp,
                          input int abort_at);
    int t;
    do_reset();
    exp_q.delete();
    n_out = 0;
    abort = 1'b0;
    gaps_en = gaps;
    ready_mode = bp ? 2 : mode;
    fork
      stream_w();
      stream_i();
      stream_p();
      watch_abort(abort_at);
    join
    if (abort) begin
      exp_q.delete();
      return;
    end
    if (bp) begin
      t = 0;
      while (!opsum_enable && t < TMO) begin
        @(negedge clk);
        t++;
      end
      repeat (20) begin
        @(negedge clk);
        check("bp_enable", int'(opsum_enable), 1);
      end
      check("bp_value", int'($signed(opsum_noc)), ev[0]);
      check("bp_no_xfer", n_out, 0);
      ready_mode = 0;
    end
    t = 0;
    while (n_out < ev.size() && t < TMO2) begin
      @(negedge clk);
      t++;
    end
    check({name, "_count"}, n_out, ev.size());
    repeat (12) @(negedge clk);
    check({name, "_no_dup"}, n_out, ev.size());
    check({name, "_done_readies"}, int'({weight_ready, ifmap_ready, ipsum_ready, opsum_enable}), 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic load_main();
    iw_size = 4'd2; c = 4'd2; f = 4'd1; n = 4'd1;
    wv = '{1, -2, 3, -1, 4, 3, 2, -3, -4, 2, -2, 1, 1, 3, 2, -4, 7, 1};
    iv = '{1, -2, 3, 2, -1, -1, 1, 1, -1, 2, 2, 4, 4, 5, 6, 2, -4, -6, 5, 3, 1, -6, 2, 3};
    pv = '{-6, -5, 11, 1, 7, 10, 20, -22};
    ev = '{2, -22, 19, 18, -20, -18, 4, 41};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    o = 4'd1;
    weight_noc = '0; ifmap_noc = '0; ipsum_noc = '0;
    weight_enable = 1'b0; ifmap_enable = 1'b0; ipsum_enable = 1'b0;

    load_main();
    run_case("main", 0, 1'b0, 1'b0, 0);

    iw_size = 4'd1; c = 4'd0; f = 4'd0; n = 4'd0;
    wv = '{1, 2, 3}; iv = '{1, 1, 1}; pv = '{5}; ev = '{11};
    run_case("minimal_bp", 0, 1'b0, 1'b1, 0);

    wv = '{-128, -128, -128}; iv = '{-128, -128, -128}; pv = '{8388607}; ev = '{-8339457};
    run_case("wrap", 0, 1'b0, 1'b0, 0);

    load_main();
    run_case("main_gaps", 1, 1'b1, 1'b0, 0);
    run_case("main_abort", 0, 1'b0, 1'b0, 3);
    run_case("main_replay", 0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
